uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver with a buffered output queue. Replaces the single-byte rxvalid/rxack
//  receiver in echo and command paths, so bursts are absorbed while downstream TX is busy.
//  Configurable data width, depth and parity. Sits between the RX pin and any byte consumer.
//  Runs in the 60 MHz clockgen domain.
// PARAMETERS
//  CLKDIV      60  clk cycles per bit (>=8); 60 MHz / 60 = 1 Mbaud
//  DATA_BITS   8   data bits per frame, 5..8, LSB first
//  DEPTH       16  FIFO entries; power of 2, >=2
//  PARITY_ODD  0   0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk         in   1               system clock (clk60)
//  rst         in   1               synchronous, active-high reset
//  rx_pin      in   1               asynchronous serial input; idles high
//  rxdata      out  DATA_BITS       FIFO head; valid only while rxvalid=1
//  rxvalid     out  1               FIFO not empty
//  rxack       in   1               pop head when rxvalid=1; ignored when rxvalid=0
//  count       out  $clog2(DEPTH)+1 number of occupied entries
//  frame_err   out  1               1-cycle pulse: stop bit sampled low
//  parity_err  out  1               1-cycle pulse: parity mismatch; tied 0 without the macro
//  overflow    out  1               sticky: a good byte arrived while the FIFO was full
//  clr_err     in   1               clears overflow; ignored when set coincides with a clear
//  busy        out  1               receiver FSM not in IDLE
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, FSM in IDLE, FIFO emptied.
//   - Synchronizer flops reset to 1.
//   - Reset asserted mid-frame abandons the frame; no partial byte is pushed.
//  Input path:
//   - rx_pin passes through a 2-flop synchroniser, resetting to 1.
//   - A falling edge on the synchronised signal in IDLE starts a frame.
//  Baud counter:
//   - Width $clog2(CLKDIV).
//   - Counts CLKDIV/2 - 1 in START, then CLKDIV - 1 per bit, so every sample lands at mid-bit.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE -> START on a falling edge.
//   - START: at mid-bit, if the line is high the edge was a glitch -> IDLE, no error flagged.
//     If the line is low -> DATA.
//   - DATA: shifts in DATA_BITS samples, LSB first; 3-bit index.
//     -> PARITY when the macro is defined, otherwise -> STOP.
//   - PARITY: sample one bit, compare against the computed parity -> STOP.
//   - STOP: sample at mid-bit, then -> IDLE.
//     - Line high and parity ok: push the byte.
//     - Line low: pulse frame_err, drop the byte.
//     - Parity bad with stop ok: pulse parity_err, drop the byte.
//  Stop-bit handling:
//   - The FSM returns to IDLE at stop mid-bit, not at the end of the stop bit.
//   - This tolerates up to half a bit of clock mismatch.
//   - A falling edge seen while still in STOP is not lost: the edge detector stays armed in IDLE.
//  FIFO:
//   - Push happens on the clock after the stop sample.
//   - Head is registered first-word-fall-through. When empty, rxvalid rises 1 cycle after the push
//     and rxdata is valid in the same cycle.
//  Boundary cases:
//   - Full with no pop: byte dropped, overflow set, count stays DEPTH.
//   - Full with pop and push in the same cycle: both happen, count unchanged, no overflow.
//   - Empty: an rxack has no effect; count never underflows.
//   - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is separate.
//   - Push and pop of a one-entry FIFO in the same cycle: head updates to the new byte, rxvalid stays 1.
// CONFIGURATION
//  Macro UART_RX_PARITY_EN:
//   - Defined: frame = start + DATA_BITS + parity + stop. Parity sense follows PARITY_ODD.
//     parity_err is live.
//   - Undefined: frame = start + DATA_BITS + stop. No PARITY state, parity_err tied to 0,
//     PARITY_ODD unused.
// STRUCTURE
//  Package uart_pkg (shared with uart_tx):
//   - FSM state localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
//   - Function clog2.
//   - Parity-compute function.
//  Sub-module sync_fifo:
//   - Parameters WIDTH and DEPTH; ports push, din, pop, dout, empty, full, count.
//   - Reusable for the TX side.
//  Receiver FSM, baud counter, shift register and synchroniser stay in this file.
// TESTING (CLKDIV=60, DATA_BITS=8, DEPTH=16)
//  1. Send 0x55 at 60 clk/bit -> rxvalid=1 with rxdata=0x55 and count=1.
//     Pulse rxack -> rxvalid=0, count=0.
//  2. Hold rx_pin low for 10 clk, then high -> no push, no frame_err, busy back to 0 within 31 clk.
//  3. Send 0xA3 with the stop bit driven low -> frame_err pulses once, count stays 0.
//  4. Send 17 bytes 0x00..0x10 with no ack -> count=16, overflow=1, rxdata=0x00.
//     Pulse clr_err -> overflow=0.
//  5. With the FIFO full, ack in the same cycle as the 17th push -> count=16, overflow=0.
//     Drain order is 0x01..0x10.
//  6. Assert rst mid-byte, then send 0x3C -> only 0x3C is received.
//     With UART_RX_PARITY_EN and PARITY_ODD=0, a wrong parity on 0x3C gives parity_err=1 and no push.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter FSM states, clog2 and parity helpers shared by the UART blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic calc_parity(input logic [7:0] d, input logic odd);
      return ^d ^ odd;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 synchronous FIFO with a first-word-fall-through head; full+pop+push does both.
module sync_fifo import uart_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [clog2(DEPTH):0] count
);
   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign empty = r_count == '0;
   assign full  = r_count == (AW+1)'(DEPTH);
   assign count = r_count;
   assign w_rd  = pop & ~empty;
   assign w_wr  = push & (~full | w_rd);
   assign dout  = empty ? '0 : r_mem[r_rd];

   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr] <= din;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wr <= r_wr + 1'b1;
         if (w_rd) r_rd <= r_rd + 1'b1;
         r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a sync_fifo; samples at mid-bit, returns to IDLE at stop mid-bit.
// Optional parity bit and parity_err enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo import uart_pkg::*; #(
   parameter int   CLKDIV     = 60,
   parameter int   DATA_BITS  = 8,
   parameter int   DEPTH      = 16,
   parameter logic PARITY_ODD = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_pin,
   output logic [DATA_BITS-1:0]  rxdata,
   output logic                  rxvalid,
   input  logic                  rxack,
   output logic [clog2(DEPTH):0] count,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overflow,
   input  logic                  clr_err,
   output logic                  busy
);
   localparam int BW = clog2(CLKDIV);
   localparam logic [BW-1:0] HALF = BW'(CLKDIV / 2 - 1);
   localparam logic [BW-1:0] FULL = BW'(CLKDIV - 1);
`ifdef UART_RX_PARITY_EN
   localparam rx_state_t POST_DATA = PARITY;
`else
   localparam rx_state_t POST_DATA = STOP;
`endif

   rx_state_t            r_state, w_state_nx;
   logic [BW-1:0]        r_baud, w_baud_nx;
   logic [DATA_BITS-1:0] r_shift, w_shift_nx;
   logic [2:0]           r_idx, w_idx_nx;
   logic                 r_sync1, r_sync2, r_prev;
   logic                 r_push, w_push;
   logic                 r_ferr, w_ferr;
   logic                 r_ovf;
   logic                 w_fall, w_tick, w_full, w_empty, w_ovf_set;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad, w_par_bad_nx;
   logic                 r_perr, w_perr;
`endif

   assign w_fall    = r_prev & ~r_sync2;
   assign w_tick    = r_baud == '0;
   assign w_ovf_set = r_push & w_full & ~rxack;
   assign rxvalid   = ~w_empty;
   assign busy      = r_state != IDLE;
   assign frame_err = r_ferr;
   assign overflow  = r_ovf;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_perr;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx_pin;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Baud counter reloads with a half bit while idle so the START sample lands mid-bit.
   always_comb begin
      w_state_nx = r_state;
      w_baud_nx  = (r_state == IDLE) ? HALF : w_tick ? FULL : r_baud - 1'b1;
      w_shift_nx = r_shift;
      w_idx_nx   = r_idx;
      w_push     = 1'b0;
      w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nx = r_par_bad;
      w_perr       = 1'b0;
`endif
      case (r_state)
         IDLE:  w_state_nx = w_fall ? START : IDLE;
         START: if (w_tick) begin
            w_state_nx = r_sync2 ? IDLE : DATA;
            w_idx_nx   = '0;
         end
         DATA:  if (w_tick) begin
            w_shift_nx = {r_sync2, r_shift[DATA_BITS-1:1]};
            w_idx_nx   = r_idx + 3'd1;
            w_state_nx = (r_idx == 3'(DATA_BITS - 1)) ? POST_DATA : DATA;
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (w_tick) begin
            w_par_bad_nx = r_sync2 != calc_parity(8'(r_shift), PARITY_ODD);
            w_state_nx   = STOP;
         end
`endif
         STOP:  if (w_tick) begin
            w_state_nx = IDLE;
            w_ferr     = ~r_sync2;
`ifdef UART_RX_PARITY_EN
            w_perr = r_sync2 & r_par_bad;
            w_push = r_sync2 & ~r_par_bad;
`else
            w_push = r_sync2;
`endif
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_baud  <= HALF;
         r_shift <= '0;
         r_idx   <= '0;
         r_push  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_baud  <= w_baud_nx;
         r_shift <= w_shift_nx;
         r_idx   <= w_idx_nx;
         r_push  <= w_push;
         r_ferr  <= w_ferr;
         r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
`ifdef UART_RX_PARITY_EN
         r_par_bad <= w_par_bad_nx;
         r_perr    <= w_perr;
`endif
      end
   end

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_push),
      .din   (r_shift),
      .pop   (rxack),
      .dout  (rxdata),
      .empty (w_empty),
      .full  (w_full),
      .count (count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, hand sequences and random frames checked against a queue model.
module tb_uart_rx_fifo;
   localparam int   CLKDIV    = 60;
   localparam int   DATA_BITS = 8;
   localparam int   DEPTH     = 16;
   localparam logic PAR_ODD   = 1'b0;

   logic       clk = 1'b0, rst = 1'b1, rx_pin = 1'b1, rxack = 1'b0, clr_err = 1'b0;
   logic [7:0] rxdata;
   logic [4:0] count;
   logic       rxvalid, frame_err, parity_err, overflow, busy;

   int         n_tests = 0, n_fail = 0, n_ferr = 0, n_perr = 0;
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         pop;
      int         exp_count;
      logic [7:0] exp_head;
      int         exp_ferr;
   } vec_t;
   vec_t tbl[7];

   uart_rx_fifo #(.CLKDIV(CLKDIV), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .PARITY_ODD(PAR_ODD)) dut (
      .clk(clk), .rst(rst), .rx_pin(rx_pin), .rxdata(rxdata), .rxvalid(rxvalid), .rxack(rxack),
      .count(count), .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
      .clr_err(clr_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".rxvalid"}, 32'(rxvalid), 32'(q.size() != 0));
      chk({tag, ".rxdata"}, 32'(rxdata), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_bad, input bit ack_stop);
      bit acked = 1'b0;
      rx_pin = 1'b0;
      repeat (CLKDIV) @(negedge clk);
      for (int i = 0; i < DATA_BITS; i++) begin
         rx_pin = d[i];
         repeat (CLKDIV) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx_pin = ^d ^ PAR_ODD ^ par_bad;
      repeat (CLKDIV) @(negedge clk);
`endif
      rx_pin = stop_ok;
      for (int i = 0; i < CLKDIV; i++) begin
         rxack = ack_stop && !acked && !busy;
         if (rxack) acked = 1'b1;
         @(negedge clk);
      end
      rxack = 1'b0;
      if (ack_stop) chk("ack_at_push", 32'(acked), 32'd1);
      rx_pin = 1'b1;
      repeat (20) @(negedge clk);
      if (ack_stop && q.size() > 0) void'(q.pop_front());
      if (stop_ok && !par_bad) begin
         if (q.size() < DEPTH) q.push_back(d);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic ack();
      rxack = 1'b1;
      @(negedge clk);
      rxack = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   initial begin
      int f0, k;
      tbl[0] = '{8'h55, 1'b1, 1'b0, 1, 8'h55, 0};
      tbl[1] = '{8'hA3, 1'b0, 1'b1, 1, 8'h55, 1};
      tbl[2] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0};
      tbl[3] = '{8'h00, 1'b1, 1'b1, 2, 8'hFF, 0};
      tbl[4] = '{8'h80, 1'b1, 1'b1, 2, 8'h00, 0};
      tbl[5] = '{8'h01, 1'b0, 1'b1, 1, 8'h80, 1};
      tbl[6] = '{8'h3C, 1'b1, 1'b1, 1, 8'h3C, 0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.rxvalid", 32'(rxvalid), 32'd0);
      chk("rst.rxdata", 32'(rxdata), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.overflow", 32'(overflow), 32'd0);
      chk("rst.frame_err", 32'(frame_err), 32'd0);
      chk("rst.parity_err", 32'(parity_err), 32'd0);

      for (int i = 0; i < 7; i++) begin
         f0 = n_ferr;
         send(tbl[i].data, tbl[i].stop_ok, 1'b0, 1'b0);
         chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].exp_count));
         chk($sformatf("tbl%0d.rxvalid", i), 32'(rxvalid), 32'd1);
         chk($sformatf("tbl%0d.rxdata", i), 32'(rxdata), 32'(tbl[i].exp_head));
         chk($sformatf("tbl%0d.frame_err", i), 32'(n_ferr - f0), 32'(tbl[i].exp_ferr));
         if (tbl[i].pop) ack();
      end
      check_state("after_tbl");
      ack();
      chk("empty_ack.count", 32'(count), 32'd0);

      f0 = n_ferr;
      rx_pin = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch.busy_hi", 32'(busy), 32'd1);
      rx_pin = 1'b1;
      k = 0;
      while (busy && k < 31) begin
         @(negedge clk);
         k++;
      end
      chk("glitch.busy_lo", 32'(busy), 32'd0);
      repeat (100) @(negedge clk);
      chk("glitch.count", 32'(count), 32'd0);
      chk("glitch.frame_err", 32'(n_ferr - f0), 32'd0);

      for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
      chk("full.count", 32'(count), 32'd16);
      chk("full.overflow", 32'(overflow), 32'd1);
      chk("full.rxdata", 32'(rxdata), 32'h00);
      check_state("full");
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_ovf = 1'b0;
      chk("clr_err.overflow", 32'(overflow), 32'd0);

      send(8'h10, 1'b1, 1'b0, 1'b1);
      chk("full_pp.count", 32'(count), 32'd16);
      chk("full_pp.overflow", 32'(overflow), 32'd0);
      check_state("full_pp");
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d", i), 32'(rxdata), 32'(i + 1));
         ack();
      end
      chk("drained.rxvalid", 32'(rxvalid), 32'd0);

      send(8'h77, 1'b1, 1'b0, 1'b0);
      rx_pin = 1'b0;
      repeat (CLKDIV) @(negedge clk);
      rx_pin = 1'b1;
      repeat (2 * CLKDIV) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.count", 32'(count), 32'd0);
      repeat (CLKDIV * 10) @(negedge clk);
      chk("midrst.count_late", 32'(count), 32'd0);
      send(8'h3C, 1'b1, 1'b0, 1'b0);
      chk("after_rst.rxdata", 32'(rxdata), 32'h3C);
      check_state("after_rst");
      ack();

`ifdef UART_RX_PARITY_EN
      f0 = n_perr;
      send(8'h3C, 1'b1, 1'b1, 1'b0);
      chk("par_bad.parity_err", 32'(n_perr - f0), 32'd1);
      chk("par_bad.count", 32'(count), 32'd0);
`endif

      for (int i = 0; i < 24; i++) begin
         logic [7:0] d;
         bit         ok;
         d  = 8'($urandom);
         ok = $urandom_range(0, 4) != 0;
         f0 = n_ferr;
         send(d, ok, 1'b0, 1'b0);
         chk($sformatf("rnd%0d.frame_err", i), 32'(n_ferr - f0), 32'(!ok));
         check_state($sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 2)) ack();
         check_state($sformatf("rnd%0d.pop", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
